// File: rtl/rvga_lsu.sv
// Load/store unit: one ld/st op at a time against a 128-bit line-granular memory port.
// Loads extract and extend a byte/half/word; stores read-modify-write the whole line.
module rvga_lsu (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         req_v_i,
  output logic         req_ready_o,
  input  logic         req_store_i,
  input  logic [2:0]   req_funct3_i,
  input  logic [31:0]  req_addr_i,
  input  logic [31:0]  req_data_i,
  input  logic [4:0]   req_rd_i,
  output logic         resp_v_o,
  input  logic         resp_ready_i,
  output logic [31:0]  resp_data_o,
  output logic [4:0]   resp_rd_o,
  output logic         resp_err_o,
  output logic         mem_v_o,
  input  logic         mem_ready_i,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_wdata_o,
  input  logic         mem_rv_i,
  input  logic [127:0] mem_rdata_i
);

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic         store_q;
  logic [2:0]   funct3_q;
  logic [3:0]   off_q;
  logic [31:0]  data_q;
  logic [4:0]   rd_q;

  logic         req_ready_d;
  logic         resp_v_d;
  logic [31:0]  resp_data_d;
  logic [4:0]   resp_rd_d;
  logic         resp_err_d;
  logic         mem_v_d;
  logic         mem_we_d;
  logic [31:0]  mem_addr_d;
  logic [127:0] mem_wdata_d;

  logic         accept;
  logic         misaligned;
  logic         illegal;
  logic         req_err;

  logic [31:0]  lane;
  logic [31:0]  load_val;
  logic [15:0]  byte_en;
  logic [127:0] wshift;
  logic [127:0] merged;

  assign accept = (state_q == IDLE) && req_v_i;

  // Size is funct3[1:0] for both loads and stores, so misalignment checks share it.
  always_comb begin
    misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                 ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    if (req_store_i) begin
      illegal = (req_funct3_i >= 3'b011);
    end else begin
      illegal = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
    end
    req_err = misaligned || illegal;
  end

  always_comb begin
    lane = 32'(mem_rdata_i >> {off_q, 3'b000});
    case (funct3_q)
      LD_B:    load_val = {{24{lane[7]}}, lane[7:0]};
      LD_H:    load_val = {{16{lane[15]}}, lane[15:0]};
      LD_W:    load_val = lane;
      LD_BU:   load_val = {24'b0, lane[7:0]};
      LD_HU:   load_val = {16'b0, lane[15:0]};
      default: load_val = 32'b0;
    endcase
  end

  // Alignment guarantees the enabled bytes never wrap past byte 15.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   byte_en = 16'h0001 << off_q;
      2'b01:   byte_en = 16'h0003 << off_q;
      default: byte_en = 16'h000F << off_q;
    endcase
    wshift = {96'b0, data_q} << {off_q, 3'b000};
    merged = mem_rdata_i;
    for (int k = 0; k < 16; k++) begin
      if (byte_en[k]) begin
        merged[8*k +: 8] = wshift[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_o;
    resp_v_d    = resp_v_o;
    resp_data_d = resp_data_o;
    resp_rd_d   = resp_rd_o;
    resp_err_d  = resp_err_o;
    mem_v_d     = mem_v_o;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;

    case (state_q)
      IDLE: begin
        if (req_v_i) begin
          req_ready_d = 1'b0;
          if (req_err) begin
            state_d     = RESP;
            resp_v_d    = 1'b1;
            resp_err_d  = 1'b1;
            resp_data_d = 32'b0;
            resp_rd_d   = 5'b0;
          end else begin
            state_d    = RD_REQ;
            mem_v_d    = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {req_addr_i[31:4], 4'b0000};
          end
        end
      end
      RD_REQ: begin
        if (mem_ready_i) begin
          state_d = RD_WAIT;
          mem_v_d = 1'b0;
        end
      end
      RD_WAIT: begin
        if (mem_rv_i) begin
          if (store_q) begin
            state_d     = WR_REQ;
            mem_v_d     = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = merged;
          end else begin
            state_d     = RESP;
            resp_v_d    = 1'b1;
            resp_err_d  = 1'b0;
            resp_data_d = load_val;
            resp_rd_d   = rd_q;
          end
        end
      end
      WR_REQ: begin
        if (mem_ready_i) begin
          state_d     = RESP;
          mem_v_d     = 1'b0;
          mem_we_d    = 1'b0;
          resp_v_d    = 1'b1;
          resp_err_d  = 1'b0;
          resp_data_d = 32'b0;
          resp_rd_d   = 5'b0;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d     = IDLE;
          resp_v_d    = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        resp_v_d    = 1'b0;
        mem_v_d     = 1'b0;
        mem_we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      req_ready_o <= 1'b1;
      resp_v_o    <= 1'b0;
      resp_data_o <= 32'b0;
      resp_rd_o   <= 5'b0;
      resp_err_o  <= 1'b0;
      mem_v_o     <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'b0;
      mem_wdata_o <= 128'b0;
    end else begin
      state_q     <= state_d;
      req_ready_o <= req_ready_d;
      resp_v_o    <= resp_v_d;
      resp_data_o <= resp_data_d;
      resp_rd_o   <= resp_rd_d;
      resp_err_o  <= resp_err_d;
      mem_v_o     <= mem_v_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
    end
  end

  // Request fields are captured only on accept and held for the whole op.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      store_q  <= 1'b0;
      funct3_q <= 3'b0;
      off_q    <= 4'b0;
      data_q   <= 32'b0;
      rd_q     <= 5'b0;
    end else if (accept) begin
      store_q  <= req_store_i;
      funct3_q <= req_funct3_i;
      off_q    <= req_addr_i[3:0];
      data_q   <= req_data_i;
      rd_q     <= req_rd_i;
    end
  end

endmodule

// File: tb/tb_rvga_lsu.sv
// Directed bench for rvga_lsu with a small line memory model and hand-computed expectations.
module tb_rvga_lsu;

  logic         clk_i;
  logic         reset_i;
  logic         req_v_i;
  logic         req_ready_o;
  logic         req_store_i;
  logic [2:0]   req_funct3_i;
  logic [31:0]  req_addr_i;
  logic [31:0]  req_data_i;
  logic [4:0]   req_rd_i;
  logic         resp_v_o;
  logic         resp_ready_i;
  logic [31:0]  resp_data_o;
  logic [4:0]   resp_rd_o;
  logic         resp_err_o;
  logic         mem_v_o;
  logic         mem_ready_i;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_rv_i;
  logic [127:0] mem_rdata_i;

  rvga_lsu dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_v_i      (req_v_i),
    .req_ready_o  (req_ready_o),
    .req_store_i  (req_store_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .req_rd_i     (req_rd_i),
    .resp_v_o     (resp_v_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_rd_o    (resp_rd_o),
    .resp_err_o   (resp_err_o),
    .mem_v_o      (mem_v_o),
    .mem_ready_i  (mem_ready_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rv_i     (mem_rv_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  int total;
  int bad;

  logic [127:0] mem [0:63];
  logic         rv_hold;
  logic         pend;
  logic [5:0]   pend_idx;
  int           mem_v_cycles;
  logic [31:0]  last_raddr;
  logic [31:0]  last_waddr;
  logic [127:0] last_wdata;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Memory model: sees the handshake at negedge, replies one cycle after accept.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 128'b0;
    mem[16] = {16'h1234, 16'h0000, 32'hCAFE_F00D, 32'h0000_0000, 32'h8000_0000};
    mem[32] = {16{8'h11}};
    mem_rv_i = 1'b0;
    mem_rdata_i = 128'b0;
    pend = 1'b0;
    pend_idx = 6'd0;
    mem_v_cycles = 0;
    last_raddr = 32'b0;
    last_waddr = 32'b0;
    last_wdata = 128'b0;
    forever begin
      @(negedge clk_i);
      if (mem_v_o) mem_v_cycles++;
      if (mem_v_o && mem_ready_i && !reset_i) begin
        if (mem_we_o) begin
          last_waddr = mem_addr_o;
          last_wdata = mem_wdata_o;
          mem[mem_addr_o[9:4]] = mem_wdata_o;
        end else begin
          last_raddr = mem_addr_o;
          pend = 1'b1;
          pend_idx = mem_addr_o[9:4];
        end
      end
      @(posedge clk_i);
      #1;
      mem_rv_i = 1'b0;
      if (pend && !rv_hold) begin
        mem_rv_i = 1'b1;
        mem_rdata_i = mem[pend_idx];
        pend = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Presents a request and returns one step after the accept edge (cycle T+1).
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] data, input logic [4:0] rd);
    int guard;
    guard = 0;
    req_v_i = 1'b1;
    req_store_i = st;
    req_funct3_i = f3;
    req_addr_i = addr;
    req_data_i = data;
    req_rd_i = rd;
    while (!req_ready_o && guard < 20) begin
      @(posedge clk_i);
      #1;
      guard++;
    end
    if (guard >= 20) checkOutput("accept_timeout", 0, 1);
    @(posedge clk_i);
    #1;
    req_v_i = 1'b0;
  endtask

  task automatic waitResp(output int lat);
    lat = 1;
    while (!resp_v_o && lat < 40) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
  endtask

  task automatic doOp(input string tag, input logic st, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                      input int exp_lat, input logic [31:0] exp_data, input logic [4:0] exp_rd,
                      input logic exp_err);
    int lat;
    applyStimulus(st, f3, addr, data, rd);
    waitResp(lat);
    checkOutput({tag, "_lat"}, lat, exp_lat);
    checkOutput({tag, "_data"}, resp_data_o, exp_data);
    checkOutput({tag, "_rd"}, resp_rd_o, exp_rd);
    checkOutput({tag, "_err"}, resp_err_o, exp_err);
    @(posedge clk_i);
    #1;
    checkOutput({tag, "_ready_after"}, {resp_v_o, req_ready_o}, 2'b01);
  endtask

  initial begin
    int lat;
    int good;
    int mv_before;
    total = 0;
    bad = 0;
    rv_hold = 1'b0;
    reset_i = 1'b1;
    req_v_i = 1'b0;
    req_store_i = 1'b0;
    req_funct3_i = 3'b0;
    req_addr_i = 32'b0;
    req_data_i = 32'b0;
    req_rd_i = 5'b0;
    resp_ready_i = 1'b1;
    mem_ready_i = 1'b1;

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_ctrl", {req_ready_o, resp_v_o, mem_v_o, mem_we_o, resp_err_o}, 5'b10000);
    checkOutput("rst_data", {resp_data_o, resp_rd_o, mem_addr_o}, 69'b0);
    checkOutput("rst_wdata", mem_wdata_o, 128'b0);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    $display("[TB] loads");
    doOp("lb", 1'b0, 3'b000, 32'h103, 32'h0, 5'd5, 3, 32'hFFFF_FF80, 5'd5, 1'b0);
    checkOutput("lb_raddr", last_raddr, 32'h100);
    doOp("lhu", 1'b0, 3'b101, 32'h10E, 32'h0, 5'd7, 3, 32'h0000_1234, 5'd7, 1'b0);
    doOp("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 5'd8, 3, 32'h0000_0080, 5'd8, 1'b0);
    doOp("lw", 1'b0, 3'b010, 32'h108, 32'h0, 5'd9, 3, 32'hCAFE_F00D, 5'd9, 1'b0);

    $display("[TB] stores");
    doOp("sh", 1'b1, 3'b001, 32'h206, 32'h5555_ABCD, 5'd3, 4, 32'h0, 5'd0, 1'b0);
    checkOutput("sh_waddr", last_waddr, 32'h200);
    checkOutput("sh_wdata", last_wdata, {{8{8'h11}}, 8'hAB, 8'hCD, {6{8'h11}}});
    doOp("sb", 1'b1, 3'b000, 32'h20F, 32'h0000_0077, 5'd4, 4, 32'h0, 5'd0, 1'b0);
    checkOutput("sb_wdata", last_wdata, {8'h77, {7{8'h11}}, 8'hAB, 8'hCD, {6{8'h11}}});
    doOp("sw", 1'b1, 3'b010, 32'h204, 32'hDEAD_BEEF, 5'd6, 4, 32'h0, 5'd0, 1'b0);
    checkOutput("sw_wdata", last_wdata, {8'h77, {7{8'h11}}, 32'hDEAD_BEEF, {4{8'h11}}});

    $display("[TB] errors");
    mv_before = mem_v_cycles;
    doOp("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0, 5'd10, 1, 32'h0, 5'd0, 1'b1);
    doOp("ld_ill", 1'b0, 3'b011, 32'h100, 32'h0, 5'd11, 1, 32'h0, 5'd0, 1'b1);
    doOp("st_ill", 1'b1, 3'b011, 32'h200, 32'h1, 5'd12, 1, 32'h0, 5'd0, 1'b1);
    doOp("sh_mis", 1'b1, 3'b001, 32'h201, 32'h1, 5'd13, 1, 32'h0, 5'd0, 1'b1);
    checkOutput("err_no_mem", mem_v_cycles - mv_before, 0);

    $display("[TB] backpressure");
    mem_ready_i = 1'b0;
    resp_ready_i = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h108, 32'h0, 5'd14);
    req_v_i = 1'b1;
    req_funct3_i = 3'b000;
    req_addr_i = 32'h300;
    good = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_v_o === 1'b1 && mem_we_o === 1'b0 && mem_addr_o === 32'h100 && req_ready_o === 1'b0)
        good++;
      @(posedge clk_i);
      #1;
    end
    checkOutput("stall_mem", good, 5);
    mem_ready_i = 1'b1;
    waitResp(lat);
    checkOutput("stall_resp_v", resp_v_o, 1'b1);
    good = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      if (resp_v_o === 1'b1 && resp_data_o === 32'hCAFE_F00D && resp_rd_o === 5'd14 &&
          req_ready_o === 1'b0)
        good++;
    end
    checkOutput("stall_resp", good, 3);
    req_v_i = 1'b0;
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("stall_done", {resp_v_o, req_ready_o, mem_v_o}, 3'b010);

    $display("[TB] reset during read wait");
    rv_hold = 1'b1;
    applyStimulus(1'b0, 3'b010, 32'h108, 32'h0, 5'd15);
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    checkOutput("rw_in_wait", {mem_v_o, resp_v_o, req_ready_o}, 3'b000);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    checkOutput("rw_reset", {req_ready_o, resp_v_o, mem_v_o}, 3'b100);
    rv_hold = 1'b0;
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    checkOutput("rw_late_rv", {req_ready_o, resp_v_o, mem_v_o}, 3'b100);
    doOp("rw_lw", 1'b0, 3'b010, 32'h204, 32'h0, 5'd16, 3, 32'hDEAD_BEEF, 5'd16, 1'b0);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
